// File: rtl/rom_arb_pkg.sv
// Shared definitions for the ROM read arbiter: ID width helper, latency modes, in-flight tag.
// Pure declarations, no logic; tags carry the widest ID supported (8 requesters).
package rom_arb_pkg;

  localparam int RD_LAT_NOREG = 1;
  localparam int RD_LAT_REG   = 2;
  localparam int ID_MAX_W     = 3;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) r++;
    return (r < 1) ? 1 : r;
  endfunction

  typedef struct packed {
    logic                v;
    logic [ID_MAX_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant, pointer advances past the winner on a grant.
// Zero latency; en=0 (downstream stall) suppresses the grant and holds the pointer.
module rr_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = clog2(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic                grant_vld,
  output logic [NUM_REQ-1:0]  grant_oh,
  output logic [ID_WIDTH-1:0] grant_idx
);

  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH:0]   idx;
  logic [ID_WIDTH:0]   nxt;
  logic [ID_WIDTH-1:0] win;
  logic                found;

  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    // Scan from rr_ptr, wrapping modulo NUM_REQ; the first requester seen wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr_q} + (ID_WIDTH+1)'(k);
      if (idx >= (ID_WIDTH+1)'(NUM_REQ)) idx = idx - (ID_WIDTH+1)'(NUM_REQ);
      if (!found && req_valid[idx[ID_WIDTH-1:0]]) begin
        found = 1'b1;
        win   = idx[ID_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    grant_vld = en & found;
    grant_idx = win;
    grant_oh  = '0;
    if (grant_vld) grant_oh[win] = 1'b1;
    nxt = {1'b0, win} + 1'b1;
    if (nxt == (ID_WIDTH+1)'(NUM_REQ)) nxt = '0;
    rr_ptr_d = grant_vld ? nxt[ID_WIDTH-1:0] : rr_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/rom_read_arbiter.sv
// Shares one ROM among NUM_REQ requesters; each response returns RD_LATENCY clocks after its grant with its requester ID.
// A response stall drops rom_clk_en and all req_ready, freezing the ROM and the tag pipe so nothing is lost.
module rom_read_arbiter
  import rom_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int RD_LATENCY = RD_LAT_REG,
  parameter int ID_WIDTH   = clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          rsp_valid,
  output logic [ID_WIDTH-1:0]           rsp_id,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  input  logic                          rsp_ready,
  output logic [ADDR_WIDTH-1:0]         rom_addr,
  output logic                          rom_clk_en,
  input  logic [DATA_WIDTH-1:0]         rom_rd_data,
  output logic                          busy
);

  tag_t                tag_q [RD_LATENCY];
  tag_t                tag_d [RD_LATENCY];
  logic                stall;
  logic                grant_vld;
  logic [ID_WIDTH-1:0] grant_idx;
  logic                unused_tag_id;

  assign stall      = rsp_valid & ~rsp_ready;
  assign rom_clk_en = ~stall;

  // Gating with rst_n keeps req_ready low while reset is held.
  rr_arbiter #(
    .NUM_REQ  (NUM_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (~stall & rst_n),
    .req_valid (req_valid),
    .grant_vld (grant_vld),
    .grant_oh  (req_ready),
    .grant_idx (grant_idx)
  );

  always_comb begin
    rom_addr = '0;
    if (grant_vld) rom_addr = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
  end

  always_comb begin
    tag_d = tag_q;
    if (!stall) begin
      tag_d[0].v  = grant_vld;
      tag_d[0].id = '0;
      tag_d[0].id[ID_WIDTH-1:0] = grant_idx;
      for (int k = 1; k < RD_LATENCY; k++) tag_d[k] = tag_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < RD_LATENCY; k++) tag_q[k] <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < RD_LATENCY; k++) busy = busy | tag_q[k].v;
  end

  assign rsp_valid     = tag_q[RD_LATENCY-1].v;
  assign rsp_id        = tag_q[RD_LATENCY-1].id[ID_WIDTH-1:0];
  assign rsp_data      = rom_rd_data;
  assign unused_tag_id = ^tag_q[RD_LATENCY-1].id;

endmodule
